raster_mem_scheduler: RTL and testbench

Sequences all write traffic into the framebuffer write port and the single-port Z-buffer on the pixel_clk domain. It performs whole-screen clears (on reset and on request), then accepts rasterizer pixel fragments and runs a read–compare–write depth test before committing colour and depth. Scanout reads use the framebuffer's other port and are outside this block. This block guarantees the Z-buffer is initialised to the far value before any triangle is drawn.

---
 rtl/raster_mem_scheduler_if.sv | 50 +++++
 rtl/raster_mem_scheduler.sv | 179 +++++++++++++++++
 tb/tb_raster_mem_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_mem_scheduler_if.sv
// ---------------------------------------------------------------------------
// raster_mem_scheduler_if
// Bundles every non-clock signal of raster_mem_scheduler: clear control,
// rasterizer fragment handshake, Z-buffer port, framebuffer write port and
// the pass/fail statistics.
//   clear_req / clear_busy / clear_done : clear request and status
//   rw_valid / rw_ready / rw_x / rw_y / rw_z / rw_color : fragment handshake
//   zb_addr / zb_we / zb_wdata / zb_rdata : single-port Z-buffer
//   fb_addr / fb_we / fb_wdata : framebuffer write port
//   pass_count / fail_count : fragment statistics since the last clear
// Modports: slave = the scheduler, master = rasterizer/memory environment.
// ---------------------------------------------------------------------------
interface raster_mem_scheduler_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8,
    parameter int Z_W     = 16
) ();
    logic               clear_req;
    logic               clear_busy;
    logic               clear_done;
    logic               rw_valid;
    logic               rw_ready;
    logic [9:0]         rw_x;
    logic [8:0]         rw_y;
    logic [Z_W-1:0]     rw_z;
    logic [COLOR_W-1:0] rw_color;
    logic [ADDR_W-1:0]  zb_addr;
    logic               zb_we;
    logic [Z_W-1:0]     zb_wdata;
    logic [Z_W-1:0]     zb_rdata;
    logic [ADDR_W-1:0]  fb_addr;
    logic               fb_we;
    logic [COLOR_W-1:0] fb_wdata;
    logic [31:0]        pass_count;
    logic [31:0]        fail_count;

    modport slave (
        input  clear_req, rw_valid, rw_x, rw_y, rw_z, rw_color, zb_rdata,
        output clear_busy, clear_done, rw_ready,
        output zb_addr, zb_we, zb_wdata, fb_addr, fb_we, fb_wdata,
        output pass_count, fail_count
    );

    modport master (
        output clear_req, rw_valid, rw_x, rw_y, rw_z, rw_color, zb_rdata,
        input  clear_busy, clear_done, rw_ready,
        input  zb_addr, zb_we, zb_wdata, fb_addr, fb_we, fb_wdata,
        input  pass_count, fail_count
    );
endinterface

// File: rtl/raster_mem_scheduler.sv
// ---------------------------------------------------------------------------
// raster_mem_scheduler
// Owns all writes into the framebuffer write port and the single-port
// Z-buffer. After reset (and on clear_req) it clears the whole screen to
// Z_CLEAR / BG_COLOR, then accepts fragments and runs a read-compare-write
// depth test (ACCEPT -> READ -> CMP), committing colour and depth when the
// fragment is strictly closer than the stored depth.
// Ports:
//   pixel_clk : clock, rising edge
//   arstn     : synchronous active-low reset
//   bus       : raster_mem_scheduler_if.slave (clear control, fragment
//               handshake, Z-buffer port, framebuffer port, statistics)
// ---------------------------------------------------------------------------
module raster_mem_scheduler #(
    parameter int                 H_ACTIVE = 640,
    parameter int                 V_ACTIVE = 480,
    parameter int                 ADDR_W   = 19,
    parameter int                 COLOR_W  = 8,
    parameter int                 Z_W      = 16,
    parameter logic [Z_W-1:0]     Z_CLEAR  = 16'hFFFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
) (
    input  logic                  pixel_clk,
    input  logic                  arstn,
    raster_mem_scheduler_if.slave bus
);
    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_CMP    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [9:0]        X_LIM     = 10'(H_ACTIVE);
    localparam logic [8:0]        Y_LIM     = 9'(V_ACTIVE);

    // y*H_ACTIVE + x as a constant shift-add over the set bits of H_ACTIVE;
    // for 640 this reduces to (y<<9) + (y<<7) + x with no multiplier.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x,
                                                   input logic [8:0] y);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int b = 0; b < ADDR_W; b++) begin
            if (H_ACTIVE[b])
                acc = acc + (ADDR_W'(y) << b);
        end
        return acc;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [1:0]         state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               clear_pending;
    logic               clear_done_r;
    logic [ADDR_W-1:0]  zb_addr_r;
    logic               zb_we_r;
    logic [Z_W-1:0]     zb_wdata_r;
    logic [ADDR_W-1:0]  fb_addr_r;
    logic               fb_we_r;
    logic [COLOR_W-1:0] fb_wdata_r;
    logic [31:0]        pass_cnt;
    logic [31:0]        fail_cnt;
    logic [ADDR_W-1:0]  frag_addr;
    logic [Z_W-1:0]     frag_z;
    logic [COLOR_W-1:0] frag_color;

    logic clear_now;
    logic ready;
    logic accept;
    logic in_range;
    logic z_pass;

    // A request arriving in the same ACCEPT cycle already beats a fragment.
    assign clear_now = clear_pending | bus.clear_req;
    assign ready     = (state == S_ACCEPT) & ~clear_now;
    assign accept    = ready & bus.rw_valid;
    assign in_range  = (bus.rw_x < X_LIM) & (bus.rw_y < Y_LIM);
    assign z_pass    = frag_z < bus.zb_rdata;

    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            state         <= S_CLEAR;
            clr_cnt       <= '0;
            clear_pending <= 1'b0;
            clear_done_r  <= 1'b0;
            zb_we_r       <= 1'b0;
            fb_we_r       <= 1'b0;
            zb_addr_r     <= '0;
            fb_addr_r     <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
        end else begin
            zb_we_r      <= 1'b0;
            fb_we_r      <= 1'b0;
            clear_done_r <= 1'b0;
            if (bus.clear_req && state != S_CLEAR)
                clear_pending <= 1'b1;
            case (state)
                S_CLEAR: begin
                    zb_we_r   <= 1'b1;
                    fb_we_r   <= 1'b1;
                    zb_addr_r <= clr_cnt;
                    fb_addr_r <= clr_cnt;
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt      <= '0;
                        clear_done_r <= 1'b1;
                        state        <= S_ACCEPT;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (clear_now) begin
                        // Entry to CLEAR consumes the request, including one
                        // arriving this very cycle.
                        clear_pending <= 1'b0;
                        clr_cnt       <= '0;
                        pass_cnt      <= '0;
                        fail_cnt      <= '0;
                        state         <= S_CLEAR;
                    end else if (accept) begin
                        if (in_range) begin
                            zb_addr_r <= pix_addr(bus.rw_x, bus.rw_y);
                            state     <= S_READ;
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                        end
                    end
                end
                S_READ: begin
                    state <= S_CMP;
                end
                default: begin
                    // S_CMP: zb_rdata holds the stored depth for frag_addr.
                    if (z_pass) begin
                        zb_we_r   <= 1'b1;
                        fb_we_r   <= 1'b1;
                        zb_addr_r <= frag_addr;
                        fb_addr_r <= frag_addr;
                        pass_cnt  <= sat_inc(pass_cnt);
                    end else begin
                        fail_cnt <= sat_inc(fail_cnt);
                    end
                    state <= S_ACCEPT;
                end
            endcase
        end
    end

    // Datapath registers: no reset, qualified by the write enables above.
    always_ff @(posedge pixel_clk) begin
        if (accept && in_range) begin
            frag_addr  <= pix_addr(bus.rw_x, bus.rw_y);
            frag_z     <= bus.rw_z;
            frag_color <= bus.rw_color;
        end
        if (state == S_CLEAR) begin
            zb_wdata_r <= Z_CLEAR;
            fb_wdata_r <= BG_COLOR;
        end else if (state == S_CMP) begin
            zb_wdata_r <= frag_z;
            fb_wdata_r <= frag_color;
        end
    end

    assign bus.clear_busy = (state == S_CLEAR);
    assign bus.clear_done = clear_done_r;
    assign bus.rw_ready   = ready;
    assign bus.zb_addr    = zb_addr_r;
    assign bus.zb_we      = zb_we_r;
    assign bus.zb_wdata   = zb_wdata_r;
    assign bus.fb_addr    = fb_addr_r;
    assign bus.fb_we      = fb_we_r;
    assign bus.fb_wdata   = fb_wdata_r;
    assign bus.pass_count = pass_cnt;
    assign bus.fail_count = fail_cnt;
endmodule

// File: tb/tb_raster_mem_scheduler.sv
// ---------------------------------------------------------------------------
// tb_raster_mem_scheduler
// Bench for raster_mem_scheduler on a reduced 640x8 screen. A behavioural
// model (per-pixel depth/colour arrays, a queue of expected memory writes and
// pass/fail totals) is compared against the DUT bus on every cycle, and the
// bench also provides the synchronous Z-buffer and framebuffer memories.
// ---------------------------------------------------------------------------
module tb_raster_mem_scheduler;
    localparam int H    = 640;
    localparam int V    = 8;
    localparam int NPIX = H * V;
    localparam int AW   = 19;

    typedef struct packed {
        logic [18:0] a;
        logic [15:0] z;
        logic [7:0]  c;
    } wr_t;

    logic pixel_clk = 1'b0;
    logic arstn     = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    raster_mem_scheduler_if #(.ADDR_W(AW), .COLOR_W(8), .Z_W(16)) bus ();

    raster_mem_scheduler #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .COLOR_W(8), .Z_W(16),
        .Z_CLEAR(16'hFFFF), .BG_COLOR(8'h00)
    ) dut (
        .pixel_clk(pixel_clk),
        .arstn    (arstn),
        .bus      (bus)
    );

    // Bench-side memories
    logic [15:0] zmem  [0:(1<<AW)-1];
    logic [7:0]  fbmem [0:(1<<AW)-1];
    bit          rst_pulse = 1'b0;

    always @(posedge pixel_clk) begin
        if (bus.zb_we) zmem[bus.zb_addr] <= bus.zb_wdata;
        if (bus.fb_we) fbmem[bus.fb_addr] <= bus.fb_wdata;
        bus.zb_rdata <= zmem[bus.zb_addr];
        rst_pulse    <= !arstn;
    end

    // Model state
    logic [15:0] zref [0:NPIX-1];
    logic [7:0]  cref [0:NPIX-1];
    wr_t         exp_q[$];
    int          mpass = 0;
    int          mfail = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [18:0] last_addr = '0;
    logic [15:0] last_z = '0;
    logic [7:0]  last_c = '0;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back('{a: 19'(i), z: 16'hFFFF, c: 8'h00});
            zref[i] = 16'hFFFF;
            cref[i] = 8'h00;
        end
        mpass = 0;
        mfail = 0;
    endtask

    task automatic model_frag(input int x, input int y, input logic [15:0] z,
                              input logic [7:0] c, output bit inr);
        int a;
        inr = (x < H) && (y < V);
        if (!inr) begin
            mfail++;
            return;
        end
        a = y * H + x;
        if (z < zref[a]) begin
            exp_q.push_back('{a: 19'(a), z: z, c: c});
            zref[a] = z;
            cref[a] = c;
            mpass++;
        end else begin
            mfail++;
        end
    endtask

    // Compare process: every write on the bus must be the next expected one.
    initial begin
        bit  prev_busy = 1'b0;
        bit  prev_done = 1'b0;
        int  busy_run  = 0;
        wr_t e;
        forever begin
            @(negedge pixel_clk);
            if (arstn) begin
                if (bus.zb_we || bus.fb_we) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_write", 64'(bus.zb_addr), 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(bus.zb_we && bus.fb_we && bus.zb_addr == e.a &&
                            bus.fb_addr == e.a && bus.zb_wdata == e.z &&
                            bus.fb_wdata == e.c, "write",
                            {bus.zb_we, bus.fb_we, bus.zb_addr, bus.fb_addr,
                             bus.zb_wdata, bus.fb_wdata},
                            {2'b11, e.a, e.a, e.z, e.c});
                    end
                    last_addr = bus.zb_addr;
                    last_z    = bus.zb_wdata;
                    last_c    = bus.fb_wdata;
                end
                if (rst_pulse) busy_run = 0;
                if (bus.clear_busy) begin
                    busy_run++;
                    chk(!bus.rw_ready, "ready_low_in_clear", 64'(bus.rw_ready), 64'h0);
                end else if (prev_busy) begin
                    chk(busy_run == NPIX, "clear_busy_len", 64'(busy_run), 64'(NPIX));
                    busy_run = 0;
                end
                if (bus.clear_done) begin
                    done_cnt++;
                    chk(bus.rw_ready && !bus.clear_busy && prev_busy && !prev_done,
                        "clear_done_timing",
                        {60'h0, bus.rw_ready, bus.clear_busy, prev_busy, prev_done},
                        64'hA);
                end
                prev_busy = bus.clear_busy;
                prev_done = bus.clear_done;
            end
        end
    end

    task automatic handshake(input int x, input int y, input logic [15:0] z,
                             input logic [7:0] c, input bit clr_first);
        bit ok;
        @(posedge pixel_clk);
        #1;
        bus.rw_x     = 10'(x);
        bus.rw_y     = 9'(y);
        bus.rw_z     = z;
        bus.rw_color = c;
        bus.rw_valid = 1'b1;
        if (clr_first) begin
            bus.clear_req = 1'b1;
            @(negedge pixel_clk);
            chk(!bus.rw_ready, "clear_beats_valid", 64'(bus.rw_ready), 64'h0);
            model_clear();
            @(posedge pixel_clk);
            #1;
            bus.clear_req = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < NPIX + 100; i++) begin
            @(negedge pixel_clk);
            if (bus.rw_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "ready_timeout", 64'h0, 64'h1);
        @(posedge pixel_clk);
        #1;
        bus.rw_valid = 1'b0;
    endtask

    task automatic send_frag(input int x, input int y, input logic [15:0] z,
                             input logic [7:0] c, input bit clr_first);
        bit inr;
        int k;
        handshake(x, y, z, c, clr_first);
        model_frag(x, y, z, c, inr);
        k = 0;
        do begin
            @(negedge pixel_clk);
            k++;
        end while (!bus.rw_ready && k < 10);
        chk(k == (inr ? 3 : 1), "ready_return", 64'(k), 64'(inr ? 3 : 1));
        #1;
        chk(exp_q.size() == 0, "write_landed", 64'(exp_q.size()), 64'h0);
        chk(bus.pass_count == 32'(mpass) && bus.fail_count == 32'(mfail), "counts",
            {bus.pass_count, bus.fail_count}, {32'(mpass), 32'(mfail)});
    endtask

    task automatic wait_clear();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < NPIX + 50; i++) begin
            @(negedge pixel_clk);
            #1;
            if (done_cnt > d0) break;
        end
        chk(done_cnt == d0 + 1, "clear_done_seen", 64'(done_cnt), 64'(d0 + 1));
        chk(exp_q.size() == 0, "clear_writes_all", 64'(exp_q.size()), 64'h0);
        chk(bus.pass_count == 0 && bus.fail_count == 0 && bus.rw_ready,
            "after_clear", {bus.pass_count, bus.fail_count}, 64'h0);
    endtask

    task automatic random_frags(input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(H - 2, H + 1);
                1:       x = $urandom_range(0, H - 1);
                default: x = $urandom_range(0, 15);
            endcase
            y = $urandom_range(0, V);
            send_frag(x, y, 16'($urandom_range(6, 40)), 8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge pixel_clk);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int d0;
        bus.clear_req = 1'b0;
        bus.rw_valid  = 1'b0;
        bus.rw_x      = '0;
        bus.rw_y      = '0;
        bus.rw_z      = '0;
        bus.rw_color  = '0;

        // Reset state and the initial clear
        arstn = 1'b0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk(!bus.zb_we && !bus.fb_we && bus.zb_addr == 0 && bus.fb_addr == 0 &&
            !bus.rw_ready && !bus.clear_done && bus.pass_count == 0 &&
            bus.fail_count == 0, "reset_state",
            {bus.zb_we, bus.fb_we, bus.rw_ready, bus.clear_done}, 64'h0);
        @(posedge pixel_clk);
        #1;
        arstn = 1'b1;
        model_clear();
        @(negedge pixel_clk);
        chk(bus.clear_busy, "busy_after_release", 64'(bus.clear_busy), 64'h1);
        wait_clear();

        // Directed fragments with hand-computed expectations
        send_frag(100, 5, 16'd50, 8'hE0, 1'b0);
        chk(last_addr == 19'd3300 && last_z == 16'd50 && last_c == 8'hE0,
            "first_frag", {last_addr, last_z, last_c}, {19'd3300, 16'd50, 8'hE0});
        chk(bus.pass_count == 1, "pass_after_first", 64'(bus.pass_count), 64'h1);
        send_frag(100, 5, 16'd50, 8'h1C, 1'b0);
        chk(bus.fail_count == 1 && bus.pass_count == 1, "equal_z_rejected",
            {bus.pass_count, bus.fail_count}, {32'd1, 32'd1});
        send_frag(100, 5, 16'd10, 8'h1C, 1'b0);
        chk(last_addr == 19'd3300 && last_z == 16'd10 && last_c == 8'h1C,
            "closer_frag", {last_addr, last_z, last_c}, {19'd3300, 16'd10, 8'h1C});
        send_frag(640, 3, 16'd1, 8'hFF, 1'b0);
        send_frag(5, 8, 16'd1, 8'hFF, 1'b0);
        chk(bus.pass_count == 2 && bus.fail_count == 3, "out_of_range",
            {bus.pass_count, bus.fail_count}, {32'd2, 32'd3});

        random_frags(150);

        // Clear request in the same cycle as a valid fragment
        send_frag(3, 3, 16'd7, 8'hAA, 1'b1);
        chk(bus.pass_count == 1 && last_addr == 19'd1923, "frag_after_clear",
            {bus.pass_count, 13'h0, last_addr}, {32'd1, 32'd1923});

        // Clear request during READ: the write lands, then CLEAR begins
        handshake(7, 2, 16'd5, 8'h55, 1'b0);
        begin
            bit inr;
            model_frag(7, 2, 16'd5, 8'h55, inr);
        end
        bus.clear_req = 1'b1;
        @(posedge pixel_clk);
        #1;
        bus.clear_req = 1'b0;
        @(negedge pixel_clk);
        chk(!bus.rw_ready, "ready_low_in_cmp", 64'(bus.rw_ready), 64'h0);
        @(negedge pixel_clk);
        #1;
        chk(exp_q.size() == 0 && !bus.rw_ready && !bus.clear_busy &&
            last_addr == 19'd1287 && last_z == 16'd5, "write_before_clear",
            {13'(exp_q.size()), bus.rw_ready, bus.clear_busy, last_addr, last_z},
            {13'h0, 2'b00, 19'd1287, 16'd5});
        model_clear();
        @(negedge pixel_clk);
        chk(bus.clear_busy && bus.pass_count == 0 && bus.fail_count == 0,
            "clear_entered", {bus.pass_count, bus.fail_count}, 64'h0);
        d0 = done_cnt;
        repeat (100) @(posedge pixel_clk);
        #1;
        bus.clear_req = 1'b1;
        @(posedge pixel_clk);
        #1;
        bus.clear_req = 1'b0;
        wait_clear();
        repeat (30) @(negedge pixel_clk);
        chk(done_cnt == d0 + 1 && !bus.clear_busy && bus.rw_ready, "clear_req_ignored",
            64'(done_cnt), 64'(d0 + 1));

        random_frags(40);

        // Reset while the clear counter is at 1000
        @(posedge pixel_clk);
        #1;
        bus.clear_req = 1'b1;
        @(posedge pixel_clk);
        #1;
        bus.clear_req = 1'b0;
        model_clear();
        for (int i = 0; i < NPIX && exp_q.size() > NPIX - 1000; i++) begin
            @(negedge pixel_clk);
            #1;
        end
        chk(exp_q.size() == NPIX - 1000, "clear_progress", 64'(exp_q.size()),
            64'(NPIX - 1000));
        arstn = 1'b0;
        @(posedge pixel_clk);
        #1;
        arstn = 1'b1;
        exp_q.delete();
        model_clear();
        @(negedge pixel_clk);
        chk(!bus.zb_we && bus.clear_busy && bus.pass_count == 0, "reset_mid_clear",
            {bus.zb_we, bus.clear_busy}, 64'h1);
        wait_clear();

        random_frags(40);

        // Final memory image against the model
        repeat (3) @(negedge pixel_clk);
        mism = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (zmem[p] !== zref[p] || fbmem[p] !== cref[p]) mism++;
        end
        chk(mism == 0, "memory_image", 64'(mism), 64'h0);
        chk(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
